// File: rtl/noc_params.sv
// Shared router parameters and port encoding for the switch allocator.
package noc_params;
   localparam int PORT_NUM  = 5;
   localparam int VC_NUM    = 2;
   localparam int VC_SIZE   = $clog2(VC_NUM);
   localparam int PORT_SIZE = $clog2(PORT_NUM);

   typedef logic [PORT_SIZE-1:0] port_t;

   localparam port_t LOCAL = port_t'(0);
   localparam port_t NORTH = port_t'(1);
   localparam port_t SOUTH = port_t'(2);
   localparam port_t WEST  = port_t'(3);
   localparam port_t EAST  = port_t'(4);
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, ptr advances past the winner on grant_en.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          grant_en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          vld,
   output logic [IW-1:0] ptr
);
   logic [IW-1:0] nxt;

   always_comb begin
      int j;
      logic [IW-1:0] jj;
      gnt = '0;
      idx = ptr;
      vld = 1'b0;
      j   = 0;
      jj  = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         jj = IW'(j);
         if (!vld && req[jj]) begin
            vld     = 1'b1;
            gnt[jj] = 1'b1;
            idx     = jj;
         end
      end
   end

   // Explicit wrap so the pointer never leaves 0..N-1 for non power-of-two N.
   assign nxt = (idx == IW'(N-1)) ? '0 : idx + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 ptr <= '0;
      else if (grant_en && vld) ptr <= nxt;
   end
endmodule

// File: rtl/switch_allocator_sep_rr.sv
// Separable input-first switch allocator: per-input VC round-robin, then per-output
// input round-robin; crossbar selects are registered for the traversal stage.
module switch_allocator_sep_rr
   import noc_params::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]    sa_req,
   input  port_t [PORT_NUM-1:0][VC_NUM-1:0]    out_port,
   output logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel,
   output logic  [PORT_NUM-1:0]                valid_sel,
   output logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xb_in_sel,
   output logic  [PORT_NUM-1:0]                xb_valid
);
   localparam logic [PORT_SIZE:0] PORT_LIM = (PORT_SIZE+1)'(PORT_NUM);

   logic  [PORT_NUM-1:0][VC_NUM-1:0]    req_m, s1_gnt;
   logic  [PORT_NUM-1:0][VC_SIZE-1:0]   s1_idx, in_ptr;
   logic  [PORT_NUM-1:0]                s1_vld, in_gnt;
   port_t [PORT_NUM-1:0]                win_port;
   logic  [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req, s2_gnt;   // [output][input]
   logic  [PORT_NUM-1:0][PORT_SIZE-1:0] s2_idx, out_ptr_unused;
   logic  [PORT_NUM-1:0]                s2_vld;

   for (genvar p = 0; p < PORT_NUM; p++) begin : g_in
      for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
         assign req_m[p][v] = sa_req[p][v] && ({1'b0, out_port[p][v]} < PORT_LIM);
      end
      // Pointer only moves when this input also wins its output, so losers keep their turn.
      rr_arbiter #(.N(VC_NUM)) u_in_arb (
         .clk      (clk),
         .rst      (rst),
         .req      (req_m[p]),
         .grant_en (in_gnt[p]),
         .gnt      (s1_gnt[p]),
         .idx      (s1_idx[p]),
         .vld      (s1_vld[p]),
         .ptr      (in_ptr[p])
      );
   end

   always_comb begin
      win_port = '0;
      for (int p = 0; p < PORT_NUM; p++)
         for (int v = 0; v < VC_NUM; v++)
            if (s1_gnt[p][v]) win_port[p] = win_port[p] | out_port[p][v];
   end

   for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
      for (genvar p = 0; p < PORT_NUM; p++) begin : g_req
         assign s2_req[o][p] = s1_vld[p] && (win_port[p] == port_t'(o));
      end
      rr_arbiter #(.N(PORT_NUM)) u_out_arb (
         .clk      (clk),
         .rst      (rst),
         .req      (s2_req[o]),
         .grant_en (1'b1),
         .gnt      (s2_gnt[o]),
         .idx      (s2_idx[o]),
         .vld      (s2_vld[o]),
         .ptr      (out_ptr_unused[o])
      );
   end

   always_comb begin
      in_gnt = '0;
      for (int o = 0; o < PORT_NUM; o++) in_gnt = in_gnt | s2_gnt[o];
   end

   always_comb begin
      valid_sel = in_gnt;
      for (int p = 0; p < PORT_NUM; p++)
         vc_sel[p] = in_gnt[p] ? s1_idx[p] : in_ptr[p];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xb_valid  <= '0;
         xb_in_sel <= '0;
      end else begin
         for (int o = 0; o < PORT_NUM; o++) begin
            xb_valid[o] <= s2_vld[o];
            if (s2_vld[o]) xb_in_sel[o] <= s2_idx[o];
         end
      end
   end
endmodule

// File: tb/tb_switch_allocator_sep_rr.sv
// Directed, table-driven bench for switch_allocator_sep_rr plus reset sequences.
module tb_switch_allocator_sep_rr;
   import noc_params::*;

   logic                                clk = 1'b0;
   logic                                rst;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]    sa_req;
   port_t [PORT_NUM-1:0][VC_NUM-1:0]    out_port;
   logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel;
   logic  [PORT_NUM-1:0]                valid_sel;
   logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xb_in_sel;
   logic  [PORT_NUM-1:0]                xb_valid;

   switch_allocator_sep_rr dut (
      .clk       (clk),
      .rst       (rst),
      .sa_req    (sa_req),
      .out_port  (out_port),
      .vc_sel    (vc_sel),
      .valid_sel (valid_sel),
      .xb_in_sel (xb_in_sel),
      .xb_valid  (xb_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic  [PORT_NUM-1:0][VC_NUM-1:0] req;
      port_t [PORT_NUM-1:0][VC_NUM-1:0] op;
      logic  [4:0]  ev;    // valid_sel
      logic  [4:0]  evc;   // vc_sel, bit p per input
      logic  [4:0]  exv;   // xb_valid (result of the previous row)
      logic  [14:0] exs;   // xb_in_sel {E,W,S,N,L}
   } vec_t;

   vec_t tbl[$];
   vec_t cur;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] ev, input logic [4:0] evc,
                               input logic [4:0] exv, input logic [14:0] exs);
      vec_t v;
      v.req = '0; v.op = '0;
      v.ev = ev; v.evc = evc; v.exv = exv; v.exs = exs;
      return v;
   endfunction

   function automatic vec_t rq(input vec_t v, input int p, input int c, input int o);
      vec_t r;
      r = v;
      r.req[p][c] = 1'b1;
      r.op[p][c]  = port_t'(o);
      return r;
   endfunction

   task automatic apply(input logic [PORT_NUM-1:0][VC_NUM-1:0] r,
                        input port_t [PORT_NUM-1:0][VC_NUM-1:0] o);
      @(negedge clk);
      sa_req   = r;
      out_port = o;
      #1;
   endtask

   task automatic contend();
      cur = mk('0, '0, '0, '0);
      cur = rq(cur, 0, 0, 3); cur = rq(cur, 1, 0, 3); cur = rq(cur, 2, 0, 3);
   endtask

   initial begin
      rst = 1'b0; sa_req = '0; out_port = '0;
      #3;
      chk("reset xb_valid", 32'(xb_valid), 0);
      chk("reset xb_in_sel", 32'(xb_in_sel), 0);
      chk("reset valid_sel", 32'(valid_sel), 0);
      chk("reset vc_sel", 32'(vc_sel), 0);
      #10 rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         apply('0, '0);
         chk($sformatf("idle%0d valid_sel", i), 32'(valid_sel), 0);
         chk($sformatf("idle%0d vc_sel", i), 32'(vc_sel), 0);
         chk($sformatf("idle%0d xb_valid", i), 32'(xb_valid), 0);
      end

      // single request NORTH VC1 -> EAST
      cur = mk(5'b00010, 5'b00010, 5'b00000, {3'd0,3'd0,3'd0,3'd0,3'd0});
      tbl.push_back(rq(cur, 1, 1, 4));
      tbl.push_back(mk(5'b00000, 5'b00000, 5'b10000, {3'd1,3'd0,3'd0,3'd0,3'd0}));
      tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, {3'd1,3'd0,3'd0,3'd0,3'd0}));
      // LOCAL/NORTH/SOUTH all want WEST: rotation L,N,S,L,N,S
      contend(); cur.ev = 5'b00001; cur.evc = 5'b00000; cur.exv = 5'b00000; cur.exs = {3'd1,3'd0,3'd0,3'd0,3'd0}; tbl.push_back(cur);
      contend(); cur.ev = 5'b00010; cur.evc = 5'b00001; cur.exv = 5'b01000; cur.exs = {3'd1,3'd0,3'd0,3'd0,3'd0}; tbl.push_back(cur);
      contend(); cur.ev = 5'b00100; cur.evc = 5'b00011; cur.exv = 5'b01000; cur.exs = {3'd1,3'd1,3'd0,3'd0,3'd0}; tbl.push_back(cur);
      contend(); cur.ev = 5'b00001; cur.evc = 5'b00110; cur.exv = 5'b01000; cur.exs = {3'd1,3'd2,3'd0,3'd0,3'd0}; tbl.push_back(cur);
      contend(); cur.ev = 5'b00010; cur.evc = 5'b00101; cur.exv = 5'b01000; cur.exs = {3'd1,3'd0,3'd0,3'd0,3'd0}; tbl.push_back(cur);
      contend(); cur.ev = 5'b00100; cur.evc = 5'b00011; cur.exv = 5'b01000; cur.exs = {3'd1,3'd1,3'd0,3'd0,3'd0}; tbl.push_back(cur);
      tbl.push_back(mk(5'b00000, 5'b00111, 5'b01000, {3'd1,3'd2,3'd0,3'd0,3'd0}));
      // EAST VC0->LOCAL, VC1->NORTH: VC alternation with pointer wrap
      cur = mk(5'b10000, 5'b00111, 5'b00000, {3'd1,3'd2,3'd0,3'd0,3'd0});
      cur = rq(cur, 4, 0, 0); cur = rq(cur, 4, 1, 1); tbl.push_back(cur);
      cur.evc = 5'b10111; cur.exv = 5'b00001; cur.exs = {3'd1,3'd2,3'd0,3'd0,3'd4}; tbl.push_back(cur);
      cur.evc = 5'b00111; cur.exv = 5'b00010; cur.exs = {3'd1,3'd2,3'd0,3'd4,3'd4}; tbl.push_back(cur);
      tbl.push_back(mk(5'b00000, 5'b10111, 5'b00001, {3'd1,3'd2,3'd0,3'd4,3'd4}));
      // NORTH loses WEST to LOCAL, keeps its pointer, wins next cycle
      cur = mk(5'b00001, 5'b10110, 5'b00000, {3'd1,3'd2,3'd0,3'd4,3'd4});
      cur = rq(cur, 0, 0, 3); cur = rq(cur, 1, 0, 3); tbl.push_back(cur);
      cur.ev = 5'b00010; cur.evc = 5'b10101; cur.exv = 5'b01000; cur.exs = {3'd1,3'd0,3'd0,3'd4,3'd4}; tbl.push_back(cur);
      // out-of-range out_port masked; WEST->WEST is legal
      cur = mk(5'b01000, 5'b11111, 5'b01000, {3'd1,3'd1,3'd0,3'd4,3'd4});
      cur = rq(cur, 2, 0, 7); cur = rq(cur, 2, 1, 5); cur = rq(cur, 3, 1, 3); tbl.push_back(cur);
      tbl.push_back(mk(5'b00000, 5'b10111, 5'b01000, {3'd1,3'd3,3'd0,3'd4,3'd4}));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].req, tbl[i].op);
         chk($sformatf("t%0d valid_sel", i), 32'(valid_sel), 32'(tbl[i].ev));
         chk($sformatf("t%0d vc_sel", i), 32'(vc_sel), 32'(tbl[i].evc));
         chk($sformatf("t%0d xb_valid", i), 32'(xb_valid), 32'(tbl[i].exv));
         chk($sformatf("t%0d xb_in_sel", i), 32'(xb_in_sel), 32'(tbl[i].exs));
      end

      // async reset mid-contention: out_ptr[WEST] moved off LOCAL first
      contend();
      apply(cur.req, cur.op);
      chk("pre-rst grant L", 32'(valid_sel), 32'b00001);
      apply(cur.req, cur.op);
      chk("pre-rst grant N", 32'(valid_sel), 32'b00010);
      @(posedge clk); #1;
      chk("pre-rst xb_valid", 32'(xb_valid), 32'b01000);
      #1 rst = 1'b0;
      #1;
      chk("async rst xb_valid", 32'(xb_valid), 0);
      chk("async rst xb_in_sel", 32'(xb_in_sel), 0);
      chk("in-rst valid_sel", 32'(valid_sel), 32'b00001);
      chk("in-rst vc_sel", 32'(vc_sel), 0);
      @(posedge clk); #1;
      chk("in-rst edge xb_valid", 32'(xb_valid), 0);
      #3 rst = 1'b1;
      @(negedge clk); #1;
      chk("post-rst grant L", 32'(valid_sel), 32'b00001);
      chk("post-rst xb_valid idle", 32'(xb_valid), 0);
      @(posedge clk); #1;
      chk("post-rst xb_valid", 32'(xb_valid), 32'b01000);
      chk("post-rst xb_in_sel", 32'(xb_in_sel), 32'(15'({3'd0,3'd0,3'd0,3'd0,3'd0})));
      chk("post-rst grant N", 32'(valid_sel), 32'b00010);
      @(posedge clk); #1;
      chk("post-rst grant S", 32'(valid_sel), 32'b00100);
      chk("post-rst xb_in_sel N", 32'(xb_in_sel), 32'(15'({3'd0,3'd1,3'd0,3'd0,3'd0})));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/switch_allocator_sep_rr.md
Name: switch_allocator_sep_rr

Overview:
- Separable, input-first switch allocator with round-robin fairness at both stages; shares the crossbar between the input blocks of the router.
- Consumes per-VC switch requests and target output ports from the input blocks.
- Returns one VC grant per input port (vc_sel/valid_sel) to the input blocks.
- Drives registered crossbar select signals for the switch-traversal stage one cycle later.

Parameters:
- PORT_NUM, 5, router ports (LOCAL, NORTH, SOUTH, WEST, EAST)
- VC_NUM, 2, virtual channels per input port
- VC_SIZE, $clog2(VC_NUM), VC index width
- PORT_SIZE, $clog2(PORT_NUM), port index width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-low
- sa_req  in  [PORT_NUM][VC_NUM]  VC has a flit at buffer head, has an assigned output VC and holds a downstream credit
- out_port  in  [PORT_NUM][VC_NUM] of port_t  requested output port per VC
- vc_sel  out  [PORT_NUM] x VC_SIZE  granted VC per input port (combinational)
- valid_sel  out  [PORT_NUM] x 1  grant valid per input port (combinational)
- xb_in_sel  out  [PORT_NUM] x PORT_SIZE  per output port: input port driving it (registered)
- xb_valid  out  [PORT_NUM] x 1  per output port: crossbar output carries a flit next cycle (registered)

Behaviour:
- Reset (rst=0, asynchronous): all input pointers and output pointers go to 0; xb_in_sel=0; xb_valid=0.
- vc_sel/valid_sel are combinational and also reflect the reset pointers while in reset.
- Stage 1, input arbitration (combinational):
  - Each input port p picks one VC among those with sa_req[p][v]=1.
  - Search is round-robin starting at in_ptr[p].
  - An out_port value >= PORT_NUM masks that request (treated as sa_req=0).
- Stage 2, output arbitration (combinational):
  - Each output port o picks one input port among the stage-1 winners whose out_port equals o.
  - Search is round-robin starting at out_ptr[o].
- Grant for input p: valid_sel[p]=1 and vc_sel[p]=stage-1 winner, only if p also won stage 2. Otherwise valid_sel[p]=0 and vc_sel[p]=in_ptr[p].
- At most one grant per input port and one per output port per cycle.
- Pointer update, on rising clk, only on a full grant:
  - in_ptr[p] <= (winning VC + 1) mod VC_NUM.
  - out_ptr[o] <= (winning input + 1) mod PORT_NUM.
  - Wrap-around is explicit; the pointer must never hold a value >= VC_NUM or >= PORT_NUM.
- A stage-1 winner that loses stage 2 leaves in_ptr[p] unchanged and retries next cycle. It must not drop its turn.
- Crossbar register: on rising clk, xb_valid[o] <= output o granted; xb_in_sel[o] <= granted input index. When no grant, xb_in_sel holds its previous value.
- Latency: request to grant is 0 cycles. Grant to crossbar select is 1 cycle.
- No internal request memory: sa_req is re-evaluated every cycle. Input blocks must deassert or refresh a request after consuming a grant.
- Any input→output pairing is legal, including p→p. Route legality belongs to the routing stage.
- Reset asserted mid-operation clears the pointers and xb_valid immediately. No grant may produce a crossbar transfer in the cycle after reset release unless it is issued after release.

Decomposition:
- noc_params holds port_t, PORT_NUM, VC_NUM, VC_SIZE, PORT_SIZE.
- One natural sub-module: rr_arbiter #(N). It takes a request vector and a grant_en, outputs a one-hot grant plus index, and holds its own pointer with asynchronous active-low reset.
- Instantiate PORT_NUM arbiters of width VC_NUM for stage 1 and PORT_NUM arbiters of width PORT_NUM for stage 2.
- grant_en for a stage-1 arbiter is the stage-2 grant of its port.

Test Plan:
- Reset, then idle with sa_req all 0 → valid_sel all 0 and xb_valid all 0 for 10 cycles; pointers stay at 0.
- Single request: input NORTH VC1 to EAST → same cycle valid_sel[NORTH]=1, vc_sel=1; next cycle xb_valid[EAST]=1, xb_in_sel[EAST]=NORTH.
- Output contention: LOCAL, NORTH and SOUTH all request WEST continuously → WEST grants rotate LOCAL, NORTH, SOUTH, LOCAL…; each input gets exactly 1 grant in every 3 cycles.
- VC fairness: input EAST, both VCs requesting distinct free outputs → grants alternate VC0, VC1, VC0; in_ptr wraps from 1 to 0.
- Non-grant retention: NORTH VC0 loses WEST to LOCAL while NORTH VC1 is idle → next cycle NORTH still offers VC0 (in_ptr unchanged), and out_ptr[WEST] now favours NORTH.
- Asynchronous reset mid-traffic: assert rst between clock edges during the saturating contention pattern → xb_valid drops to 0 without waiting for clk; after release, arbitration restarts from pointer 0 (LOCAL first).
